cpu_run_ctrl: RTL and testbench

Run controller that sits directly upstream of the single-cycle CPU core and also consumes its end-of-run result. It streams a program image into instruction/data memory, releases the CPU, and counts execution cycles until the CPU raises `halt` or a timeout expires. It then walks the register file and streams all 32 registers out on a valid/ready port. This gives a synthesizable replacement for the bench-side load / wait-for-halt / dump sequence.

---
 rtl/cpu_run_ctrl.sv | 121 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads a program image into memory, releases the CPU until halt or timeout,
// then streams all 32 register-file entries out on a valid/ready port.
module cpu_run_ctrl #(
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 100000,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  input  logic        halt,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic        dump_last,
  output logic [31:0] cycles,
  output logic        timeout,
  output logic        done
);

  localparam int unsigned WcntW = $clog2(MAX_WORDS + 1);
  localparam logic [WcntW-1:0] MaxWords = WcntW'(MAX_WORDS);

  typedef enum logic [1:0] {StLoad, StRun, StDump, StDone} state_e;

  state_e           state_q, state_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [31:0]      cycles_q, cycles_d;
  logic [4:0]       idx_q, idx_d;
  logic             timeout_q, timeout_d;

  logic             ld_hs, dump_hs;
  logic [WcntW-1:0] wcnt_inc;
  logic [31:0]      cycles_inc;
  logic [31:0]      wcnt_word;

  assign ld_hs      = ld_valid & ld_ready;
  assign dump_hs    = dump_valid & dump_ready;
  assign wcnt_inc   = wcnt_q + WcntW'(1);
  assign cycles_inc = cycles_q + 32'd1;
  assign wcnt_word  = 32'(wcnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      wcnt_q    <= '0;
      cycles_q  <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      cycles_q  <= cycles_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    cycles_d  = cycles_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    case (state_q)
      StLoad: begin
        if (ld_hs) begin
          wcnt_d = wcnt_inc;
          if (ld_last || (wcnt_inc == MaxWords)) state_d = StRun;
        end
      end
      StRun: begin
        // halt takes priority over the timeout boundary
        if (halt) begin
          timeout_d = 1'b0;
          state_d   = StDump;
        end else begin
          cycles_d = cycles_inc;
          if (cycles_inc == TIMEOUT) begin
            timeout_d = 1'b1;
            state_d   = StDump;
          end
        end
      end
      StDump: begin
        if (dump_hs) begin
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'd31) state_d = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    ld_ready   = (state_q == StLoad) && !rst;
    mem_we     = ld_hs;
    mem_addr   = BASE_ADDR + (wcnt_word << 2);
    mem_wdata  = ld_data;
    cpu_hold   = rst || (state_q != StRun);
    rf_raddr   = idx_q;
    dump_valid = (state_q == StDump);
    dump_data  = rf_rdata;
    dump_last  = (state_q == StDump) && (idx_q == 5'd31);
    done       = (state_q == StDone);
  end

  assign cycles  = cycles_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: scoreboard queues hold expected memory writes and
// register dump words; a combinational RF model answers rf_raddr.
module tb_cpu_run_ctrl;

  localparam int unsigned   MaxWords = 4;
  localparam int unsigned   Timeout  = 20;
  localparam logic [31:0]   BaseAddr = 32'h0;

  logic        clk = 1'b0;
  logic        rst, ld_valid, ld_ready, ld_last, mem_we, cpu_hold, halt;
  logic        dump_valid, dump_ready, dump_last, timeout, done;
  logic [31:0] ld_data, mem_addr, mem_wdata, rf_rdata, dump_data, cycles;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_mul = 32'd1, rf_salt = 32'd0;

  int errors = 0;
  int checks = 0;
  logic [63:0] wq[$];
  logic [31:0] dq[$];
  logic [63:0] mon_e;
  int m_wcnt;
  bit m_loading;

  always #5 clk = ~clk;

  assign rf_rdata = 32'(rf_raddr) * rf_mul + rf_salt;

  cpu_run_ctrl #(
    .MAX_WORDS(MaxWords),
    .TIMEOUT  (Timeout),
    .BASE_ADDR(BaseAddr)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .halt      (halt),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_data (dump_data),
    .dump_last (dump_last),
    .cycles    (cycles),
    .timeout   (timeout),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Memory write scoreboard
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write observed addr=%0h data=%0h expected=none", mem_addr,
               mem_wdata);
      end else begin
        mon_e = wq.pop_front();
        chk("wr_addr", mem_addr, mon_e[63:32]);
        chk("wr_data", mem_wdata, mon_e[31:0]);
      end
    end
  end

  // All tasks start and end at posedge+#1.
  task automatic do_reset();
    wq.delete();
    rst = 1'b1; ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; ld_last = 1'b0;
    halt = 1'b0; dump_ready = 1'b0;
    @(negedge clk);
    chk1("rst_ld_ready", ld_ready, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; ld_valid = 1'b0;
    m_wcnt = 0; m_loading = 1'b1;
    @(negedge clk);
    chk1("post_rst_ld_ready", ld_ready, 1'b1);
    chk1("post_rst_cpu_hold", cpu_hold, 1'b1);
    chk1("post_rst_mem_we", mem_we, 1'b0);
    chk1("post_rst_dump_valid", dump_valid, 1'b0);
    chk1("post_rst_dump_last", dump_last, 1'b0);
    chk("post_rst_raddr", 32'(rf_raddr), 32'd0);
    chk1("post_rst_done", done, 1'b0);
    chk("post_rst_cycles", cycles, 32'd0);
    chk1("post_rst_timeout", timeout, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    bit was_loading;
    was_loading = m_loading;
    ld_valid = 1'b1; ld_data = data; ld_last = last;
    if (m_loading) begin
      wq.push_back({BaseAddr + 32'(m_wcnt) * 32'd4, data});
      m_wcnt++;
      if (last || (m_wcnt == int'(MaxWords))) m_loading = 1'b0;
    end
    @(negedge clk);
    chk1("ld_ready", ld_ready, was_loading);
    chk1("ld_cpu_hold", cpu_hold, was_loading);
    @(posedge clk); #1;
  endtask

  task automatic load_prog();
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0010_0093, 1'b0);
    send_word(32'h0000_006F, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic run_halt(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk1("run_hold", cpu_hold, 1'b0);
      @(posedge clk); #1;
    end
    halt = 1'b1;
    @(negedge clk);
    chk("cycles_at_halt", cycles, 32'(n));
    chk1("run_hold_halt", cpu_hold, 1'b0);
    @(posedge clk); #1;
    halt = 1'b0;
    @(negedge clk);
    chk("cycles_after_halt", cycles, 32'(n));
    chk1("timeout_after_halt", timeout, 1'b0);
    chk1("first_dump_valid", dump_valid, 1'b1);
    chk1("dump_hold", cpu_hold, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic run_timeout();
    int runs = 0;
    bit stop = 1'b0;
    for (int c = 0; c < 100 && !stop; c++) begin
      @(negedge clk);
      if (cpu_hold === 1'b0) runs++;
      else stop = 1'b1;
      if (!stop) begin
        @(posedge clk); #1;
      end
    end
    chk("timeout_run_cycles", 32'(runs), 32'(Timeout));
    chk("timeout_cycles", cycles, 32'(Timeout));
    chk1("timeout_flag", timeout, 1'b1);
    chk1("timeout_dump_valid", dump_valid, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_dump(input bit rnd, input int stop_at, input logic [31:0] mul,
                         input logic [31:0] salt);
    int got = 0;
    logic [31:0] pe;
    rf_mul = mul; rf_salt = salt;
    chk("writes_left", 32'(wq.size()), 32'd0);
    dq.delete();
    for (int i = 0; i < 32; i++) dq.push_back(32'(i) * mul + salt);
    for (int c = 0; c < 400 && got < stop_at; c++) begin
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      chk1("dump_valid", dump_valid, 1'b1);
      if (dump_valid === 1'b1) begin
        chk("dump_data", dump_data, dq[0]);
        chk("dump_raddr", 32'(rf_raddr), 32'(got));
        chk1("dump_last", dump_last, got == 31);
        if (dump_ready) begin
          pe = dq.pop_front();
          got++;
        end
      end
      @(posedge clk); #1;
    end
    dump_ready = 1'b0;
    chk("dump_count", 32'(got), 32'(stop_at));
  endtask

  task automatic chk_done(input logic [31:0] cyc, input logic to);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1("done", done, 1'b1);
      chk1("done_dump_valid", dump_valid, 1'b0);
      chk1("done_ld_ready", ld_ready, 1'b0);
      chk1("done_cpu_hold", cpu_hold, 1'b1);
      chk("done_cycles", cycles, cyc);
      chk1("done_timeout", timeout, to);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Load 3 words, halt after 5 RUN cycles, dump RF with value=index
    do_reset();
    load_prog();
    run_halt(5);
    do_dump(1'b0, 32, 32'd1, 32'd0);
    chk_done(32'd5, 1'b0);

    // Halt never asserted: forced stop at TIMEOUT
    do_reset();
    load_prog();
    run_timeout();
    do_dump(1'b1, 32, 32'h0101_0101, 32'h5A);
    chk_done(32'(Timeout), 1'b1);

    // Halt on the 20th RUN cycle wins over the timeout boundary
    do_reset();
    load_prog();
    run_halt(int'(Timeout) - 1);
    do_dump(1'b1, 32, 32'd3, 32'h1000);
    chk_done(32'(Timeout - 1), 1'b0);

    // Capacity limit: 6 words offered, only MaxWords written
    do_reset();
    for (int i = 0; i < 6; i++) send_word(32'hA0 + 32'(i), 1'b0);
    ld_valid = 1'b0;
    @(negedge clk);
    chk1("cap_ld_ready", ld_ready, 1'b0);
    chk("cap_writes", 32'(m_wcnt), 32'(MaxWords));
    @(posedge clk); #1;
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;

    // Abort mid-dump at index 10, then a full fresh run
    do_dump(1'b1, 10, 32'd7, 32'h77);
    do_reset();
    load_prog();
    run_halt(7);
    do_dump(1'b1, 32, 32'd9, 32'h33);
    chk_done(32'd7, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

endmodule
